// File: rtl/regfile_pkg.sv
// Shared encodings and default sizing for the parametrised register file.
package regfile_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_STATUS_REG = 30;
    localparam int DEF_TAP_REG    = 29;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

endpackage

// File: rtl/regfile_status_ctl.sv
// Status register update rule: exception events beat normal writes; sticky status resists nonzero overwrites.
module regfile_status_ctl
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter bit STATUS_STICKY = 1'b1
) (
    input  logic [DATA_WIDTH-1:0] storedStatus,
    input  logic                  writeHit,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  eventValid,
    input  logic [DATA_WIDTH-1:0] eventData,
    output logic                  statusWe,
    output logic [DATA_WIDTH-1:0] statusNext
);

    logic eventFire;
    logic writeOk;

    assign eventFire = eventValid && (eventData != '0);
    // A write of zero always clears, so software can re-arm a sticky status.
    assign writeOk    = writeHit && (!STATUS_STICKY || (storedStatus == '0) || (writeData == '0));
    assign statusWe   = eventFire || writeOk;
    assign statusNext = eventFire ? eventData : writeData;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with sweep clear, optional zero register, write bypass and sticky status.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter bit ZERO_REG      = 1'b1,
    parameter bit BYPASS        = 1'b1,
    parameter int STATUS_REG    = DEF_STATUS_REG,
    parameter bit STATUS_STICKY = 1'b1,
    parameter int TAP_REG       = DEF_TAP_REG
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    input  logic                  ctrl_statusValid,
    input  logic [DATA_WIDTH-1:0] data_status,
    input  logic                  ctrl_clear,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] data_tap,
    output logic [DATA_WIDTH-1:0] data_statusReg,
    output logic [0:0]            debugState
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] STATUS_IDX = ADDR_WIDTH'(STATUS_REG);
    localparam logic [ADDR_WIDTH-1:0] TAP_IDX    = ADDR_WIDTH'(TAP_REG);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(DEPTH - 1);

    if ((STATUS_REG >= DEPTH) || (TAP_REG >= DEPTH) || (ZERO_REG && (STATUS_REG == 0))) begin : gParamCheck
        $error("regfile_mp: STATUS_REG/TAP_REG out of range or STATUS_REG hidden by ZERO_REG");
    end

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clrIdx;
    logic                  live;
    logic                  normWe;
    logic                  statusHit;
    logic                  statusWe;
    logic [DATA_WIDTH-1:0] statusNext;
    logic                  isReady;

    // ctrl_ready is a plain level: while it is 0 every write, status event and
    // clear request is dropped (never queued) and all data outputs read 0.
    assign isReady   = (state == ST_READY);
    assign live      = isReady && ctrl_reset;
    assign normWe    = live && ctrl_writeEnable && (ctrl_writeReg != STATUS_IDX)
                       && !(ZERO_REG && (ctrl_writeReg == '0));
    assign statusHit = live && ctrl_writeEnable && (ctrl_writeReg == STATUS_IDX);
    assign debugState = state;

    regfile_status_ctl #(
        .DATA_WIDTH   (DATA_WIDTH),
        .STATUS_STICKY(STATUS_STICKY)
    ) uStatusCtl (
        .storedStatus(regs[STATUS_IDX]),
        .writeHit    (statusHit),
        .writeData   (data_writeReg),
        .eventValid  (live && ctrl_statusValid),
        .eventData   (data_status),
        .statusWe    (statusWe),
        .statusNext  (statusNext)
    );

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            state      <= ST_CLEAR;
            clrIdx     <= '0;
            ctrl_ready <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clrIdx <= clrIdx + 1'b1;
                    if (clrIdx == LAST_IDX) begin
                        state      <= ST_READY;
                        ctrl_ready <= 1'b1;
                    end
                end
                default: begin
                    if (ctrl_clear) begin
                        state      <= ST_CLEAR;
                        clrIdx     <= '0;
                        ctrl_ready <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Storage has no reset of its own so it can map onto RAM; the sweep zeroes it.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            if (state == ST_CLEAR) begin
                regs[clrIdx] <= '0;
            end else begin
                if (normWe) regs[ctrl_writeReg] <= data_writeReg;
                if (statusWe) regs[STATUS_IDX] <= statusNext;
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] readPort(input logic [ADDR_WIDTH-1:0] idx);
        logic [DATA_WIDTH-1:0] val;
        val = regs[idx];
        if (!isReady) begin
            val = '0;
        end else if (ZERO_REG && (idx == '0)) begin
            val = '0;
        end else if (BYPASS && statusWe && (idx == STATUS_IDX)) begin
            val = statusNext;
        end else if (BYPASS && normWe && (idx == ctrl_writeReg)) begin
            val = data_writeReg;
        end
        return val;
    endfunction

    always_comb begin
        data_readRegA  = readPort(ctrl_readRegA);
        data_readRegB  = readPort(ctrl_readRegB);
        data_tap       = isReady ? regs[TAP_IDX] : '0;
        data_statusReg = isReady ? regs[STATUS_IDX] : '0;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised scoreboard bench for regfile_mp against an array-level reference model.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int SREG  = 30;
    localparam int TREG  = 29;

    logic          clock = 1'b0;
    logic          ctrl_reset = 1'b0;
    logic          ctrl_writeEnable = 1'b0;
    logic [AW-1:0] ctrl_writeReg = '0;
    logic [DW-1:0] data_writeReg = '0;
    logic [AW-1:0] ctrl_readRegA = '0;
    logic [AW-1:0] ctrl_readRegB = '0;
    logic [DW-1:0] data_readRegA;
    logic [DW-1:0] data_readRegB;
    logic          ctrl_statusValid = 1'b0;
    logic [DW-1:0] data_status = '0;
    logic          ctrl_clear = 1'b0;
    logic          ctrl_ready;
    logic [DW-1:0] data_tap;
    logic [DW-1:0] data_statusReg;
    logic [0:0]    debugState;

    always #5 clock = ~clock;

    regfile_mp dut (
        .clock           (clock),
        .ctrl_reset      (ctrl_reset),
        .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg   (ctrl_writeReg),
        .data_writeReg   (data_writeReg),
        .ctrl_readRegA   (ctrl_readRegA),
        .ctrl_readRegB   (ctrl_readRegB),
        .data_readRegA   (data_readRegA),
        .data_readRegB   (data_readRegB),
        .ctrl_statusValid(ctrl_statusValid),
        .data_status     (data_status),
        .ctrl_clear      (ctrl_clear),
        .ctrl_ready      (ctrl_ready),
        .data_tap        (data_tap),
        .data_statusReg  (data_statusReg),
        .debugState      (debugState)
    );

    // Reference model: register contents plus the number of sweep cycles still owed.
    logic [DW-1:0] mdl [DEPTH];
    int            busy;
    logic [4*DW:0] exp_q[$];
    int            checks = 0;
    int            passes = 0;

    function automatic logic [DW-1:0] expRead(input logic [AW-1:0] idx);
        logic evt;
        logic acc;
        if (busy != 0 || idx == 0) return '0;
        if (!ctrl_reset) return mdl[idx];
        evt = ctrl_statusValid && (data_status != 0);
        acc = ctrl_writeEnable && (ctrl_writeReg == SREG) && (mdl[SREG] == 0 || data_writeReg == 0);
        if (idx == SREG) begin
            if (evt) return data_status;
            if (acc) return data_writeReg;
            return mdl[SREG];
        end
        if (ctrl_writeEnable && idx == ctrl_writeReg) return data_writeReg;
        return mdl[idx];
    endfunction

    task automatic modelEdge();
        logic evt;
        logic acc;
        if (!ctrl_reset) begin
            busy = DEPTH;
            for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        end else if (busy > 0) begin
            busy--;
        end else begin
            evt = ctrl_statusValid && (data_status != 0);
            acc = ctrl_writeEnable && (ctrl_writeReg == SREG) && (mdl[SREG] == 0 || data_writeReg == 0);
            if (ctrl_writeEnable && ctrl_writeReg != 0 && ctrl_writeReg != SREG)
                mdl[ctrl_writeReg] = data_writeReg;
            if (evt) mdl[SREG] = data_status;
            else if (acc) mdl[SREG] = data_writeReg;
            if (ctrl_clear) begin
                busy = DEPTH;
                for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
            end
        end
    endtask

    task automatic cyc(input logic rst, input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic sv, input logic [DW-1:0] sd, input logic clr);
        logic [DW-1:0] tapExp;
        logic [DW-1:0] stExp;
        ctrl_reset = rst; ctrl_writeEnable = we; ctrl_writeReg = wa; data_writeReg = wd;
        ctrl_readRegA = ra; ctrl_readRegB = rb; ctrl_statusValid = sv; data_status = sd; ctrl_clear = clr;
        tapExp = (busy == 0) ? mdl[TREG] : '0;
        stExp  = (busy == 0) ? mdl[SREG] : '0;
        exp_q.push_back({(busy == 0), expRead(ra), expRead(rb), tapExp, stExp});
        @(posedge clock);
        modelEdge();
        #1;
    endtask

    task automatic idle(input int n, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, ra, rb, 0, 0, 0);
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle while inputs are stable.
    always @(negedge clock) begin
        logic [4*DW:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ready",    {31'd0, ctrl_ready}, {31'd0, e[4*DW]});
            check("readA",    data_readRegA,  e[4*DW-1:3*DW]);
            check("readB",    data_readRegB,  e[3*DW-1:2*DW]);
            check("tap",      data_tap,       e[2*DW-1:DW]);
            check("statusRg", data_statusReg, e[DW-1:0]);
        end
    end

    initial begin
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        busy = DEPTH;
        // First edge with reset low gives the DUT a defined state before checking starts.
        @(posedge clock);
        #1;
        cyc(0, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0);
        cyc(0, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0);
        for (int i = 0; i < 34; i++) cyc(1, 1, 5, 32'hDEADBEEF, 5, 5, 0, 0, 0);
        cyc(1, 1, 0, 32'h1234, 0, 5, 0, 0, 0);
        idle(1, 0, 5);
        cyc(1, 1, 7, 32'hA5A5A5A5, 5, 7, 0, 0, 0);
        idle(1, 7, 7);
        cyc(1, 1, SREG, 32'h11, SREG, 7, 1, 32'h4, 0);
        cyc(1, 1, SREG, 32'h22, SREG, SREG, 0, 0, 0);
        cyc(1, 1, SREG, 32'h0, SREG, 5, 0, 0, 0);
        cyc(1, 1, SREG, 32'h22, SREG, SREG, 0, 0, 0);
        cyc(1, 1, SREG, 32'h33, SREG, SREG, 1, 32'h0, 0);
        idle(1, SREG, 0);
        cyc(1, 1, TREG, 32'hCAFE, TREG, SREG, 0, 0, 0);
        idle(2, TREG, 7);
        cyc(1, 1, 9, 32'h99, 9, TREG, 0, 0, 1);
        idle(33, 9, 7);
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 0, AW'(i), AW'(DEPTH - 1 - i), 0, 0, 0);
        cyc(1, 1, 3, 32'h3, 3, 3, 0, 0, 1);
        idle(10, 3, 5);
        cyc(0, 1, 3, 32'h3, 3, 3, 1, 32'h7, 1);
        idle(33, 3, SREG);

        for (int n = 0; n < 500; n++) begin
            wa = ($urandom_range(0, 3) == 0) ? AW'(SREG) : AW'($urandom_range(0, DEPTH - 1));
            wd = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
            ra = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
            rb = ($urandom_range(0, 2) == 0) ? AW'(SREG) : AW'($urandom_range(0, DEPTH - 1));
            cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), wa, wd, ra, rb,
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0) ? '0 : DW'($urandom_range(1, 255)),
                ($urandom_range(0, 149) == 0));
        end
        idle(1, 0, 0);
        @(negedge clock);
        #1;
        check("queueDrained", DW'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the processor register file; instantiated by the CPU decode/writeback stages.
- Generic width and depth, RAM-friendly storage cleared by a sequential sweep instead of per-flop reset.
- Optional hardwired-zero register 0 and same-cycle write-to-read bypass.
- Status register with priority, sticky external exception capture, plus one parametrised debug/tap output.

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH.
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes.
- BYPASS, 1, 1 = read of the register being written this cycle returns the effective write data.
- STATUS_REG, 30, index of the status register.
- STATUS_STICKY, 1, 1 = nonzero status is protected from nonzero normal writes.
- TAP_REG, 29, index driven on data_tap.

Ports:
- clock  in  1  single clock, all state on rising edge.
- ctrl_reset  in  1  synchronous, active-low reset.
- ctrl_writeEnable  in  1  normal write strobe.
- ctrl_writeReg  in  ADDR_WIDTH  write index.
- data_writeReg  in  DATA_WIDTH  write data.
- ctrl_readRegA  in  ADDR_WIDTH  read index A.
- ctrl_readRegB  in  ADDR_WIDTH  read index B.
- data_readRegA  out  DATA_WIDTH  read data A (combinational).
- data_readRegB  out  DATA_WIDTH  read data B (combinational).
- ctrl_statusValid  in  1  external exception event strobe.
- data_status  in  DATA_WIDTH  exception code; 0 means no event.
- ctrl_clear  in  1  request full-file clear sweep.
- ctrl_ready  out  1  1 = sweep done, file usable.
- data_tap  out  DATA_WIDTH  contents of TAP_REG.
- data_statusReg  out  DATA_WIDTH  contents of STATUS_REG.

Behaviour:
- FSM states: CLEAR, READY.
- ctrl_reset low at a clock edge:
  - state <= CLEAR, clr_idx <= 0, ctrl_ready <= 0.
  - No register write performed that cycle.
  - Reset mid-sweep restarts the sweep at index 0.
- CLEAR:
  - Each cycle writes 0 to entry clr_idx, clr_idx <= clr_idx+1.
  - At clr_idx == DEPTH-1 the entry is zeroed and state <= READY.
  - ctrl_ready = 1 on the cycle after; sweep takes exactly DEPTH cycles after reset deassertion.
  - Normal writes, status events and ctrl_clear are dropped, not queued.
  - All read outputs, data_tap and data_statusReg are forced to 0.
- READY:
  - ctrl_clear = 1 -> next cycle state CLEAR, clr_idx 0, ctrl_ready 0; that cycle's normal write is still performed.
- Normal write (READY, ctrl_writeEnable = 1): register ctrl_writeReg <= data_writeReg at the edge.
  - ZERO_REG = 1 and index 0: write discarded.
- Status register, effective next value, priority high to low:
  1. ctrl_statusValid = 1 and data_status != 0 -> data_status; overrides a simultaneous normal write to STATUS_REG.
  2. Normal write to STATUS_REG:
     - STATUS_STICKY = 0 -> accepted.
     - STATUS_STICKY = 1 -> accepted if stored status == 0 or data_writeReg == 0 (write of 0 clears); otherwise ignored.
  3. Hold.
- Reads:
  - Asynchronous from storage.
  - Index 0 with ZERO_REG = 1 -> 0.
  - BYPASS = 1 and the read index equals an index being updated this cycle -> effective next value of that register (including status priority and sticky rules).
  - A dropped or ignored write yields no bypass.
  - BYPASS = 0 -> old value until the edge.
- data_tap and data_statusReg follow storage, bypass not applied; both 0 during CLEAR.
- Widths: all indices unsigned; no arithmetic on data.
- Elaboration error if STATUS_REG or TAP_REG >= DEPTH, or STATUS_REG == 0 with ZERO_REG = 1.

Decomposition:
- Package regfile_pkg: state encoding (ST_CLEAR, ST_READY); default constants DATA_WIDTH, ADDR_WIDTH, STATUS_REG, TAP_REG.
- One sub-module, regfile_status_ctl:
  - Inputs: stored status, normal write hit/data, status event.
  - Outputs: status write enable and effective next status value.
  - Reused by the bypass logic.
- Storage array, clear FSM and read/bypass muxing stay in regfile_mp.

Test Plan:
- Hold ctrl_reset low 2 cycles, release; write r5 = 0xDEADBEEF every cycle.
  -> ctrl_ready rises exactly 32 cycles after release; r5 reads 0 until then.
  -> Write accepted on the first READY cycle; r5 reads 0xDEADBEEF next cycle.
- Write r0 = 0x1234; read A = 0.
  -> data_readRegA = 0 (ZERO_REG = 1).
- Write r7 = 0xA5A5A5A5 while ctrl_readRegB = 7 in the same cycle.
  -> data_readRegB = 0xA5A5A5A5 before the edge (BYPASS = 1); old value with BYPASS = 0.
- Same cycle: normal write r30 = 0x11 and status event data_status = 0x4.
  -> r30 = 0x4.
  -> A later write of 0x22 is ignored, r30 stays 0x4.
  -> Write of 0 clears r30 to 0; then a write of 0x22 gives r30 = 0x22.
- Write r29 = 0xCAFE, then assert ctrl_clear.
  -> data_tap = 0xCAFE, then 0 during the sweep.
  -> ctrl_ready low for 32 cycles; all registers read 0 after.
- Assert reset at sweep index 10.
  -> Sweep restarts; ctrl_ready rises 32 cycles after the reset release.
